// File: rtl/regfile_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_stream_ctrl
// Purpose  : Sequencer between a 32-bit word stream and a 4 x 512-bit register
//            file (A1..A4). LOAD gathers BEATS input words into one register
//            write; UNLOAD reads one register and emits it as BEATS output
//            words, least-significant word first.
// Ports    :
//   clk, reset            clock (posedge) / asynchronous active-high reset
//   cmd_valid/ready       command handshake; cmd_op 0=LOAD 1=UNLOAD,
//                         cmd_reg selects A1..A4 (00..11)
//   in_valid/ready/data   input word stream (used by LOAD)
//   out_valid/ready/data  output word stream (produced by UNLOAD)
//   rf_we/regselect/      register-file write enable, select and write data
//   rf_wdata
//   rf_rdata              register-file read data (combinational on select)
//   busy                  high whenever the sequencer is not idle
//   done                  one-cycle pulse when a command completes
// Revision : 1.0 - initial release
// ============================================================================
module regfile_stream_ctrl #(
  parameter int DATA_W = 512,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [1:0]        cmd_reg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              rf_we,
  output logic [1:0]        rf_regselect,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done
);

  localparam int BEATS = DATA_W / WORD_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_LOAD   = 3'd1;
  localparam logic [2:0] c_ST_WRITE  = 3'd2;
  localparam logic [2:0] c_ST_READ   = 3'd3;
  localparam logic [2:0] c_ST_UNLOAD = 3'd4;
  localparam logic [2:0] c_ST_DONE   = 3'd5;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_buf;
  logic [1:0]        r_reg;
  logic              r_we;

  // Word view of the buffer; the output mux indexes this with the beat count.
  logic [WORD_W-1:0] w_words [BEATS];

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_word_view
      assign w_words[gi] = r_buf[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_reg   <= 2'b00;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (cmd_valid) begin
            r_reg   <= cmd_reg;
            r_cnt   <= '0;
            r_state <= cmd_op ? c_ST_READ : c_ST_LOAD;
          end
        end
        c_ST_LOAD: begin
          if (in_valid) begin
            // Constant-slice write per beat keeps the buffer update a plain
            // per-word enable rather than a variable shifter.
            for (int b = 0; b < BEATS; b++) begin
              if (r_cnt == CNT_W'(b)) begin
                r_buf[b*WORD_W +: WORD_W] <= in_data;
              end
            end
            if (r_cnt == c_LAST_BEAT) begin
              // Register the write strobe so it is clean for the whole
              // WRITE cycle, including the file's falling-edge capture.
              r_we    <= 1'b1;
              r_state <= c_ST_WRITE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_ST_WRITE: begin
          r_state <= c_ST_DONE;
        end
        c_ST_READ: begin
          r_buf   <= rf_rdata;
          r_cnt   <= '0;
          r_state <= c_ST_UNLOAD;
        end
        c_ST_UNLOAD: begin
          if (out_ready) begin
            if (r_cnt == c_LAST_BEAT) begin
              r_state <= c_ST_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = (r_state == c_ST_IDLE);
  assign in_ready     = (r_state == c_ST_LOAD);
  assign out_valid    = (r_state == c_ST_UNLOAD);
  assign busy         = (r_state != c_ST_IDLE);
  assign done         = (r_state == c_ST_DONE);
  assign rf_we        = r_we;
  assign rf_regselect = r_reg;
  assign rf_wdata     = r_buf;
  // Buffer and count only change on a taken beat, so this is stable under
  // backpressure.
  assign out_data     = w_words[r_cnt];

endmodule
`default_nettype wire
